// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register I/O blocks (PISO reader, LED driver).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_pkg;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LOW,
    HIGH,
    DONE
  } sr_state_e;

  // Board defaults: chain length and system clocks per device phase.
  localparam int SR_WIDTH_DEFAULT   = 12;
  localparam int SR_CLK_DIV_DEFAULT = 4;

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_phase_tick.sv
// Phase divider: counts 0..CLK_DIV-1, flags the last count, restarts on clr_i.
// Latency: phase_end_o is a decode of the count register (no input path).
// Backpressure: none; free-running between clears.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   clr_i       synchronous clear (count restarts at 0 on the next edge)
//   phase_end_o high while count == CLK_DIV-1
module sr_phase_tick
  import sr_pkg::*;
#(
  parameter int CLK_DIV = SR_CLK_DIV_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic phase_end_o
);

  localparam int CW = cnt_w(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign phase_end_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    // Wrap at phase end as well as on clear so a stalled owner never
    // sees the counter run past CLK_DIV-1.
    if (clr_i || phase_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sr_piso_reader.sv
// Reader for a 74HC165-class PISO chain: load pulse, WIDTH shifts MSB first, one-cycle valid.
// Latency: start high before edge k -> valid in the cycle after edge k+1+CLK_DIV*(1+2*WIDTH).
// Backpressure: none; start is ignored (not queued) while busy.
//
// Ports:
//   CLK        system clock
//   RESET      synchronous active-high reset; aborts a scan in progress
//   start      scan request, acted on only in IDLE
//   SR_Q       serial data from the device's last stage (QH)
//   SR_CK      device shift clock (registered)
//   SR_LOAD_B  device parallel load, active low (registered)
//   data       last completed scan, data[WIDTH-1] = first bit shifted in
//   valid      one-cycle strobe marking a new data word
//   busy       high in every state except IDLE
module sr_piso_reader
  import sr_pkg::*;
#(
  parameter int WIDTH   = SR_WIDTH_DEFAULT,
  parameter int CLK_DIV = SR_CLK_DIV_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             SR_Q,
  output logic             SR_CK,
  output logic             SR_LOAD_B,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  sr_state_e        state_q, state_d;
  logic             start_q;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sr_ck_q, sr_ck_d;
  logic             sr_load_b_q, sr_load_b_d;
  logic             phase_end;
  logic             state_chg;

  // Divider restarts whenever the state changes, so every phase is a
  // full CLK_DIV cycles long regardless of where the count was.
  assign state_chg = (state_d != state_q);

  sr_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clr_i       (state_chg),
    .phase_end_o (phase_end)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        // start is registered once (board pin input); this register is also
        // what lets a held request re-enter LOAD right after DONE.
        if (start_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (phase_end) begin
          bit_d   = BIT_LAST;
          state_d = LOW;
        end
      end
      LOW: begin
        // Sample QH at the end of the low half, just before SR_CK rises.
        if (phase_end) begin
          shift_d = {shift_q[WIDTH-2:0], SR_Q};
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          if (bit_q == '0) begin
            data_d  = shift_q;
            state_d = DONE;
          end else begin
            bit_d   = bit_q - 1'b1;
            state_d = LOW;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Device pins come straight from flops keyed on the next state, so
    // they change only at clock edges and carry no combinational glitches.
    sr_ck_d     = (state_d == HIGH);
    sr_load_b_d = (state_d != LOAD);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      sr_ck_q     <= 1'b0;
      sr_load_b_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      sr_ck_q     <= sr_ck_d;
      sr_load_b_q <= sr_load_b_d;
    end
  end

  assign SR_CK     = sr_ck_q;
  assign SR_LOAD_B = sr_load_b_q;
  assign data      = data_q;
  assign valid     = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sr_piso_reader.sv
module tb_sr_piso_reader;

  localparam int W  = 12;
  localparam int D  = 2;
  localparam int W2 = 2;
  localparam int D2 = 1;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESET = 1'b1;

  // Main instance: WIDTH=12, CLK_DIV=2
  logic          start = 1'b0;
  logic          sr_q, sr_ck, sr_load_b, valid, busy;
  logic [W-1:0]  data;
  // Edge instance: WIDTH=2, CLK_DIV=1
  logic          start2 = 1'b0;
  logic          sr_q2, sr_ck2, sr_load_b2, valid2, busy2;
  logic [W2-1:0] data2;

  int n_cmp = 0;
  int n_bad = 0;

  sr_piso_reader #(.WIDTH(W), .CLK_DIV(D)) u_dut (
    .CLK(CLK), .RESET(RESET), .start(start), .SR_Q(sr_q),
    .SR_CK(sr_ck), .SR_LOAD_B(sr_load_b), .data(data), .valid(valid), .busy(busy)
  );

  sr_piso_reader #(.WIDTH(W2), .CLK_DIV(D2)) u_dut2 (
    .CLK(CLK), .RESET(RESET), .start(start2), .SR_Q(sr_q2),
    .SR_CK(sr_ck2), .SR_LOAD_B(sr_load_b2), .data(data2), .valid(valid2), .busy(busy2)
  );

  // 74HC165 model: parallel load while LOAD_B low, shift on SR_CK rising, QH = MSB.
  logic [W-1:0]  pat = '0, dev = '0;
  logic          ck_prev = 1'b0;
  always @(posedge CLK) begin
    ck_prev <= sr_ck;
    if (!sr_load_b)             dev <= pat;
    else if (sr_ck && !ck_prev) dev <= dev << 1;
  end
  assign sr_q = dev[W-1];

  logic [W2-1:0] pat2 = '0, dev2 = '0;
  logic          ck_prev2 = 1'b0;
  always @(posedge CLK) begin
    ck_prev2 <= sr_ck2;
    if (!sr_load_b2)              dev2 <= pat2;
    else if (sr_ck2 && !ck_prev2) dev2 <= dev2 << 1;
  end
  assign sr_q2 = dev2[W2-1];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One scan on the main instance; start is high for exactly one edge (edge k).
  task automatic scan_main(input logic [W-1:0] p, input logic [W-1:0] exp_d,
                           input int exp_lat, input string tag);
    int   lat = -1;
    int   nv = 0, nck = 0, nld = 0, first_ld = -1;
    logic ckp = 1'b0;
    pat = p;
    start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    for (int n = 1; n <= exp_lat + 6; n++) begin
      @(posedge CLK); #1;
      if (valid) begin
        nv++;
        if (lat < 0) lat = n;
      end
      if (!sr_load_b) begin
        nld++;
        if (first_ld < 0) first_ld = n;
      end
      if (sr_ck && !ckp) nck++;
      ckp = sr_ck;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, data, exp_d);
    chk({tag, " valid pulses"}, nv, 1);
    chk({tag, " sr_ck rises"}, nck, W);
    chk({tag, " load cycles"}, nld, D);
    chk({tag, " load start"}, first_ld, 1);
    chk({tag, " idle after"}, busy, 0);
  endtask

  typedef struct {
    logic [W-1:0] pat;
    logic [W-1:0] exp_data;
    int           exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   v1, v2, idle_cnt, nv, nrise, nck, lat2;
    logic [W-1:0] d1, d2;
    logic bprev, ckp;

    // 1 + CLK_DIV*(1+2*WIDTH) = 1 + 2*25 = 51
    vecs[0] = '{12'hE2A, 12'hE2A, 51};
    vecs[1] = '{12'hFFF, 12'hFFF, 51};
    vecs[2] = '{12'h000, 12'h000, 51};
    vecs[3] = '{12'hA5A, 12'hA5A, 51};
    vecs[4] = '{12'h801, 12'h801, 51};

    // Reset
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst sr_ck", sr_ck, 0);
    chk("rst load_b", sr_load_b, 1);
    chk("rst data", data, 0);
    chk("rst valid", valid, 0);
    chk("rst busy", busy, 0);
    chk("rst data2", data2, 0);
    nv = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge CLK); #1;
      if (busy || !sr_load_b || sr_ck || valid) nv++;
    end
    chk("no activity without start", nv, 0);

    // Table-driven single scans
    for (int i = 0; i < 5; i++) begin
      scan_main(vecs[i].pat, vecs[i].exp_data, vecs[i].exp_lat, $sformatf("scan%0d", i));
      repeat (2) @(posedge CLK);
      #1;
    end

    // Back-to-back with start held high
    pat = 12'h001; start = 1'b1;
    v1 = -1; v2 = -1; idle_cnt = 0; d1 = '0; d2 = '0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge CLK); #1;
      if (valid) begin
        if (v1 < 0) begin
          v1 = n; d1 = data; pat = 12'h800;
        end else begin
          v2 = n; d2 = data; start = 1'b0;
          break;
        end
      end else if (v1 >= 0 && !busy) begin
        idle_cnt++;
      end
    end
    start = 1'b0;
    chk("b2b first valid", v1, 52);
    chk("b2b spacing", v2 - v1, 52);
    chk("b2b data1", d1, 12'h001);
    chk("b2b data2", d2, 12'h800);
    chk("b2b idle cycles", idle_cnt, 1);
    repeat (6) @(posedge CLK);
    #1 chk("b2b stops", busy, 0);

    // Start pulsed mid-scan is ignored
    pat = 12'h3C3; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    nv = 0; nrise = 0; bprev = 1'b0;
    for (int n = 1; n <= 120; n++) begin
      @(posedge CLK); #1;
      if (n == 20) start = 1'b1;
      if (n == 21) start = 1'b0;
      if (valid) nv++;
      if (busy && !bprev) nrise++;
      bprev = busy;
    end
    chk("ignored start valid pulses", nv, 1);
    chk("ignored start busy windows", nrise, 1);
    chk("ignored start data", data, 12'h3C3);

    // Abort during the 6th HIGH phase
    pat = 12'hF0F; start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    nck = 0; ckp = 1'b0;
    for (int n = 1; n <= 100 && nck < 6; n++) begin
      @(posedge CLK); #1;
      if (sr_ck && !ckp) nck++;
      ckp = sr_ck;
    end
    chk("abort reached high6", nck, 6);
    chk("abort in high", sr_ck, 1);
    RESET = 1'b1;
    @(posedge CLK); #1 RESET = 1'b0;
    chk("abort sr_ck", sr_ck, 0);
    chk("abort load_b", sr_load_b, 1);
    chk("abort data", data, 0);
    chk("abort valid", valid, 0);
    chk("abort busy", busy, 0);
    nv = 0;
    for (int n = 0; n < 60; n++) begin
      @(posedge CLK); #1;
      if (valid || busy) nv++;
    end
    chk("abort no valid", nv, 0);
    scan_main(12'h5A5, 12'h5A5, 51, "recover");

    // Edge parameters: WIDTH=2, CLK_DIV=1 -> latency 1 + 1*5 = 6
    pat2 = 2'b10; start2 = 1'b1;
    @(posedge CLK); #1 start2 = 1'b0;
    lat2 = -1; nv = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK); #1;
      if (n == 1) chk("edge load_b", sr_load_b2, 0);
      if (n >= 2 && n <= 5) chk($sformatf("edge sr_ck n%0d", n), sr_ck2, (n % 2 == 1) ? 1 : 0);
      if (valid2) begin
        nv++;
        if (lat2 < 0) lat2 = n;
      end
    end
    chk("edge latency", lat2, 6);
    chk("edge valid pulses", nv, 1);
    chk("edge data", data2, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
